// File: rtl/bram_row_reader.sv
// Drains a window of image rows from BRAM port B and presents them as a valid/ready pixel stream.
// Optional feature macro: BRAM_ROW_READER_LAST_EN (per-row pix_last marker).
module bram_row_reader #(
   parameter int IMG_WIDTH = 640,
   parameter int BASE_ADDR = 0,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic              clkb,
   input  logic              reset,
   input  logic              go,
   input  logic [2:0]        window,
   output logic              enb,
   output logic [ADDR_W-1:0] addrb,
   input  logic [DATA_W-1:0] doutb,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_last,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = 13;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [CNT_W-1:0]  COL_MAX   = CNT_W'(IMG_WIDTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

   logic [1:0]        state;
   logic              go_q;
   logic [2:0]        rows;
   logic [CNT_W-1:0]  row;
   logic [CNT_W-1:0]  col;
   logic [CNT_W-1:0]  row_max;
   logic [ADDR_W-1:0] addr_q;
   logic              rd_vld_q;

   logic [DATA_W-1:0] fifo_dat [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        occ;
   logic [1:0]        occ_nxt;

   logic start;
   logic room;
   logic issue;
   logic last_col;
   logic last_rd;
   logic push;
   logic pop;

   assign start    = go & ~go_q & ((state == S_IDLE) | (state == S_DONE));
   // Words in the skid buffer plus the one on doutb never exceed two.
   assign room     = (occ == 2'd0) | ((occ == 2'd1) & ~rd_vld_q);
   assign issue    = (state == S_READ) & room;
   assign row_max  = CNT_W'(rows) - CNT_W'(1);
   assign last_col = (col == COL_MAX);
   assign last_rd  = issue & last_col & (row == row_max);

   // Returned data bypasses the buffer only when it is empty and the sink takes it.
   assign pop     = (occ != 2'd0) & pix_ready;
   assign push    = rd_vld_q & ~((occ == 2'd0) & pix_ready);
   assign occ_nxt = occ + {1'b0, push} - {1'b0, pop};

   always_ff @(posedge clkb or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         go_q     <= 1'b0;
         rows     <= 3'd0;
         row      <= '0;
         col      <= '0;
         addr_q   <= ADDR_BASE;
         rd_vld_q <= 1'b0;
      end else begin
         go_q     <= go;
         rd_vld_q <= issue;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  rows   <= window;
                  row    <= '0;
                  col    <= '0;
                  addr_q <= ADDR_BASE;
                  state  <= (window == 3'd0) ? S_DONE : S_READ;
               end
            end
            S_READ: begin
               if (issue) begin
                  if (last_col) begin
                     col <= '0;
                     row <= row + CNT_W'(1);
                  end else begin
                     col <= col + CNT_W'(1);
                  end
                  // Hold the final address so addrb never points past the frame.
                  if (last_rd) begin
                     state <= S_DRAIN;
                  end else begin
                     addr_q <= addr_q + ADDR_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (occ_nxt == 2'd0) begin
                  state <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clkb or posedge reset) begin
      if (reset) begin
         occ         <= 2'd0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_dat[0] <= '0;
         fifo_dat[1] <= '0;
      end else begin
         occ <= occ_nxt;
         if (push) begin
            fifo_dat[wr_ptr] <= doutb;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

`ifdef BRAM_ROW_READER_LAST_EN
   logic rd_last_q;
   logic fifo_last [2];

   always_ff @(posedge clkb or posedge reset) begin
      if (reset) begin
         rd_last_q    <= 1'b0;
         fifo_last[0] <= 1'b0;
         fifo_last[1] <= 1'b0;
      end else begin
         rd_last_q <= issue & last_col;
         if (push) begin
            fifo_last[wr_ptr] <= rd_last_q;
         end
      end
   end

   assign pix_last = (occ != 2'd0) ? fifo_last[rd_ptr] : (rd_vld_q & rd_last_q);
`else
   assign pix_last = 1'b0;
`endif

   assign enb       = issue;
   assign addrb     = addr_q;
   assign pix_valid = (occ != 2'd0) | rd_vld_q;
   assign pix_data  = (occ != 2'd0) ? fifo_dat[rd_ptr] : (rd_vld_q ? doutb : '0);
   assign busy      = (state == S_READ) | (state == S_DRAIN);
   assign done      = (state == S_DONE);

endmodule

// File: tb/tb_bram_row_reader.sv
// Bench for bram_row_reader: BRAM model with word n = n, expected stream is words 0..rows*W-1 in order.
module tb_bram_row_reader;

   localparam int W    = 640;
   localparam int BASE = 0;
   localparam int NMAX = 7 * W;

   logic        clkb = 1'b0;
   logic        reset;
   logic        go;
   logic [2:0]  window;
   logic        enb;
   logic [31:0] addrb;
   logic [31:0] doutb = 32'h0;
   logic [31:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_last;
   logic        busy;
   logic        done;

   logic [31:0] bram [NMAX];
   int          bram_a;
   int          checks = 0;
   int          errors = 0;
   int          cyc;
   int          hs_out;

   always #5 clkb = ~clkb;

   always @(posedge clkb) begin
      if (enb) begin
         bram_a = int'(addrb) - BASE;
         if (bram_a >= 0 && bram_a < NMAX) doutb <= bram[bram_a];
         else doutb <= 32'hDEAD_BEEF;
      end
   end

   bram_row_reader #(
      .IMG_WIDTH (W),
      .BASE_ADDR (BASE),
      .ADDR_W    (32),
      .DATA_W    (32)
   ) dut (
      .clkb      (clkb),
      .reset     (reset),
      .go        (go),
      .window    (window),
      .enb       (enb),
      .addrb     (addrb),
      .doutb     (doutb),
      .pix_data  (pix_data),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_last  (pix_last),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clkb);
      #1;
      cyc++;
   endtask

   function automatic logic exp_last(input int n);
      logic l;
      l = ((n % W) == W - 1);
`ifndef BRAM_ROW_READER_LAST_EN
      l = 1'b0;
`endif
      return l;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_bit({tag, "_enb"}, enb, 1'b0);
      check({tag, "_addrb"}, addrb, BASE);
      check_bit({tag, "_pix_valid"}, pix_valid, 1'b0);
      check({tag, "_pix_data"}, pix_data, 32'h0);
      check_bit({tag, "_pix_last"}, pix_last, 1'b0);
      check_bit({tag, "_busy"}, busy, 1'b0);
      check_bit({tag, "_done"}, done, 1'b0);
   endtask

   // hold_go keeps go high and inserts a 0->1 glitch at cycle 100 while reading.
   task automatic run_frame(input int rows, input bit rnd, input int rst_at,
                            input bit hold_go, output int hs);
      int          q[$];
      int          issued;
      int          first_v;
      int          last_hs;
      int          done_cyc;
      int          n;
      bit          prev_stall;
      logic [31:0] prev_dat;
      logic        prev_last;

      for (int i = 0; i < rows * W; i++) q.push_back(i);
      issued = 0; hs = 0; first_v = -1; last_hs = -1; done_cyc = -1;
      prev_stall = 1'b0; prev_dat = 32'h0; prev_last = 1'b0;

      window = rows[2:0];
      go = 1'b0;
      pix_ready = 1'b1;
      step();
      go = 1'b1;
      cyc = 0;
      step();
      check_bit("start_busy", busy, 1'b1);
      check_bit("start_done", done, 1'b0);
      check_bit("start_enb", enb, 1'b1);
      check("start_addrb", addrb, BASE);

      while (cyc < 12000) begin
         if (!hold_go) go = 1'b0;
         else if (cyc == 100) go = 1'b0;
         else if (cyc == 101) go = 1'b1;
         pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;

         if (prev_stall) begin
            check_bit("stall_valid", pix_valid, 1'b1);
            check("stall_data", pix_data, prev_dat);
            check_bit("stall_last", pix_last, prev_last);
         end
         if (enb) begin
            check("rd_addr", addrb, BASE + issued);
            checks++;
            assert (issued + 1 - hs <= 2) else begin
               errors++;
               $error("FAIL outstanding observed=%0d required<=2", issued + 1 - hs);
            end
            issued++;
         end
         if (pix_valid && first_v < 0) first_v = cyc;
         if (pix_valid && pix_ready) begin
            if (q.size() == 0) begin
               check("extra_pixel", pix_data, 32'hFFFF_FFFF);
            end else begin
               n = q.pop_front();
               check("pix_data", pix_data, n);
               check_bit("pix_last", pix_last, exp_last(n));
            end
            hs++;
            last_hs = cyc;
         end
         prev_stall = pix_valid && !pix_ready;
         prev_dat   = pix_data;
         prev_last  = pix_last;

         if (rst_at >= 0 && hs == rst_at) return;
         if (done) begin
            done_cyc = cyc;
            break;
         end
         step();
      end

      checks++;
      assert (done_cyc > 0) else begin
         errors++;
         $error("FAIL done_timeout observed=%0d required>0", done_cyc);
      end
      check("hs_count", hs, rows * W);
      check("issued_count", issued, rows * W);
      check_bit("end_busy", busy, 1'b0);
      check_bit("end_valid", pix_valid, 1'b0);
      if (!rnd) begin
         check("first_valid_cyc", first_v, 2);
         check("last_hs_cyc", last_hs, rows * W + 1);
         check("done_cyc", done_cyc, rows * W + 2);
      end
   endtask

   initial begin
      bit seen;

      for (int i = 0; i < NMAX; i++) bram[i] = i;
      reset = 1'b1; go = 1'b0; window = 3'd0; pix_ready = 1'b0; cyc = 0;
      step();
      step();
      check_reset_outputs("rst");
      reset = 1'b0;
      step();

      // Empty window: straight to DONE with no reads.
      window = 3'd0;
      go = 1'b1;
      check_bit("w0_pre_done", done, 1'b0);
      step();
      check_bit("w0_done", done, 1'b1);
      check_bit("w0_busy", busy, 1'b0);
      seen = 1'b0;
      go = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (pix_valid || enb) seen = 1'b1;
         step();
      end
      check_bit("w0_no_activity", seen, 1'b0);

      run_frame(7, 1'b0, -1, 1'b0, hs_out);
      run_frame(2, 1'b1, -1, 1'b0, hs_out);
      run_frame(3, 1'b0, -1, 1'b0, hs_out);

      // Asynchronous reset in the middle of a frame.
      run_frame(7, 1'b0, 1000, 1'b0, hs_out);
      check("rst_at_hs", hs_out, 1000);
      reset = 1'b1;
      #1;
      check_reset_outputs("midrst");
      step();
      step();
      reset = 1'b0;
      go = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (pix_valid || enb) seen = 1'b1;
      end
      check_bit("post_rst_quiet", seen, 1'b0);
      run_frame(1, 1'b0, -1, 1'b0, hs_out);

      // go held high with a second edge during READ: one frame only.
      run_frame(1, 1'b0, -1, 1'b1, hs_out);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (pix_valid || enb || busy || !done) seen = 1'b1;
      end
      check_bit("held_go_no_restart", seen, 1'b0);
      run_frame(1, 1'b1, -1, 1'b0, hs_out);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
